// File: rtl/lockin_sequencer.sv
// -----------------------------------------------------------------------------
// lockin_sequencer
//
// Sequences one gated lock-in photon-counting acquisition: clears the
// counters, alternates light-on / light-off phases of half_period clocks for
// num_cycles full modulation cycles (add gate in the on phase, subtract gate
// in the off phase, each optionally blanked for blank_cycles clocks after the
// phase edge), then latches the counters and reports done.
//
// Optional feature macro: LOCKIN_BLANKING_EN
//   defined   : blank_cycles delays each gate and must be < half_period.
//   undefined : blank_cycles is ignored (treated as 0) and not validated.
//
// Ports
//   clock_50_mhz      in   system clock, rising edge
//   reset             in   synchronous active-high reset
//   start             in   one-cycle run request (IDLE only)
//   abort             in   terminate run, no latch
//   half_period       in   clocks per phase (TIMER_WIDTH)
//   blank_cycles      in   blanking clocks at start of each phase (CYCLE_WIDTH)
//   num_cycles        in   full on+off cycles per run (CYCLE_WIDTH)
//   light_source_pin  out  excitation drive
//   add_enable        out  counter gate, light-on window
//   subtract_enable   out  counter gate, light-off window
//   counter_clear     out  one-cycle clear strobe
//   counter_latch     out  one-cycle capture strobe
//   busy              out  high whenever not idle
//   done              out  one-cycle normal-completion strobe
//   config_error      out  one-cycle strobe on rejected start
//   cycles_completed  out  full cycles finished in current/last run
//
// TIMER_WIDTH is expected to be >= CYCLE_WIDTH (blank_cycles is compared
// against timer values after zero-extension).
// -----------------------------------------------------------------------------
module lockin_sequencer #(
   parameter int TIMER_WIDTH = 32,
   parameter int CYCLE_WIDTH = 16
) (
   input  logic                   clock_50_mhz,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [TIMER_WIDTH-1:0] half_period,
   input  logic [CYCLE_WIDTH-1:0] blank_cycles,
   input  logic [CYCLE_WIDTH-1:0] num_cycles,
   output logic                   light_source_pin,
   output logic                   add_enable,
   output logic                   subtract_enable,
   output logic                   counter_clear,
   output logic                   counter_latch,
   output logic                   busy,
   output logic                   done,
   output logic                   config_error,
   output logic [CYCLE_WIDTH-1:0] cycles_completed
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_ON    = 3'd2;
   localparam logic [2:0] S_OFF   = 3'd3;
   localparam logic [2:0] S_LATCH = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   // The state register runs one clock ahead of the outputs: every output is
   // registered from the state/timer held during the preceding clock. This is
   // what places busy/counter_clear on cycle 1 and the light on cycle 2.
   logic [2:0]             r_state;
   logic [TIMER_WIDTH-1:0] r_timer;
   logic [TIMER_WIDTH-1:0] r_half;
   logic [CYCLE_WIDTH-1:0] r_blank;
   logic [CYCLE_WIDTH-1:0] r_num;
   logic [CYCLE_WIDTH-1:0] r_cycles;

   logic r_light;
   logic r_add;
   logic r_sub;
   logic r_clr;
   logic r_latch;
   logic r_busy;
   logic r_done;
   logic r_cerr;

   logic [CYCLE_WIDTH-1:0] w_blank_in;
   logic                   w_cfg_ok;
   logic                   w_last;
   logic                   w_gate_open;
   logic [CYCLE_WIDTH-1:0] w_cycles_next;

`ifdef LOCKIN_BLANKING_EN
   assign w_blank_in = blank_cycles;
   assign w_cfg_ok   = (half_period != '0) && (num_cycles != '0) &&
                       (TIMER_WIDTH'(blank_cycles) < half_period);
`else
   // Port stays for pin compatibility; its value is masked off so the gates
   // coincide with their phases.
   assign w_blank_in = blank_cycles & {CYCLE_WIDTH{1'b0}};
   assign w_cfg_ok   = (half_period != '0) && (num_cycles != '0);
`endif

   // r_half is nonzero inside a run, so half_period-1 never wraps.
   assign w_last        = (r_timer == (r_half - TIMER_WIDTH'(1)));
   assign w_gate_open   = (r_timer >= TIMER_WIDTH'(r_blank));
   assign w_cycles_next = r_cycles + CYCLE_WIDTH'(1);

   always_ff @(posedge clock_50_mhz) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_timer  <= '0;
         r_half   <= '0;
         r_blank  <= '0;
         r_num    <= '0;
         r_cycles <= '0;
         r_light  <= 1'b0;
         r_add    <= 1'b0;
         r_sub    <= 1'b0;
         r_clr    <= 1'b0;
         r_latch  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_cerr   <= 1'b0;
      end else begin
         // Every output defaults low; the case below raises what the
         // current state calls for. An abort therefore only has to redirect
         // the state to drop all outputs on this edge.
         r_light <= 1'b0;
         r_add   <= 1'b0;
         r_sub   <= 1'b0;
         r_clr   <= 1'b0;
         r_latch <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cerr  <= 1'b0;

         if (abort && (r_state != S_IDLE)) begin
            // cycles_completed intentionally holds its value.
            r_state <= S_IDLE;
            r_timer <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  // start together with abort is dropped silently.
                  if (start && !abort) begin
                     if (w_cfg_ok) begin
                        r_half   <= half_period;
                        r_blank  <= w_blank_in;
                        r_num    <= num_cycles;
                        r_cycles <= '0;
                        r_state  <= S_CLEAR;
                     end else begin
                        r_cerr <= 1'b1;
                     end
                  end
               end

               S_CLEAR: begin
                  r_busy  <= 1'b1;
                  r_clr   <= 1'b1;
                  r_timer <= '0;
                  r_state <= S_ON;
               end

               S_ON: begin
                  r_busy  <= 1'b1;
                  r_light <= 1'b1;
                  r_add   <= w_gate_open;
                  if (w_last) begin
                     r_timer <= '0;
                     r_state <= S_OFF;
                  end else begin
                     r_timer <= r_timer + TIMER_WIDTH'(1);
                  end
               end

               S_OFF: begin
                  r_busy <= 1'b1;
                  r_sub  <= w_gate_open;
                  if (w_last) begin
                     r_timer  <= '0;
                     r_cycles <= w_cycles_next;
                     r_state  <= (w_cycles_next == r_num) ? S_LATCH : S_ON;
                  end else begin
                     r_timer <= r_timer + TIMER_WIDTH'(1);
                  end
               end

               S_LATCH: begin
                  r_busy  <= 1'b1;
                  r_latch <= 1'b1;
                  r_state <= S_DONE;
               end

               S_DONE: begin
                  r_busy  <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end

               default: begin
                  r_state <= S_IDLE;
                  r_timer <= '0;
               end
            endcase
         end
      end
   end

   assign light_source_pin = r_light;
   assign add_enable       = r_add;
   assign subtract_enable  = r_sub;
   assign counter_clear    = r_clr;
   assign counter_latch    = r_latch;
   assign busy             = r_busy;
   assign done             = r_done;
   assign config_error     = r_cerr;
   assign cycles_completed = r_cycles;

endmodule

// File: tb/tb_lockin_sequencer.sv
// Scoreboard bench for lockin_sequencer. The stimulus process computes the
// expected per-cycle output waveform of each request from the phase/cycle
// arithmetic and queues it; the monitor compares every cycle on the falling
// edge, expecting idle outputs when no entry is due.
module tb_lockin_sequencer;

`ifdef LOCKIN_BLANKING_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] half_period = '0;
   logic [15:0] blank_cycles = '0;
   logic [15:0] num_cycles = '0;
   logic        light, add_en, sub_en, clr, latch, busy, done, cerr;
   logic [15:0] cycles_completed;

   lockin_sequencer #(.TIMER_WIDTH(32), .CYCLE_WIDTH(16)) dut (
      .clock_50_mhz     (clk),
      .reset            (reset),
      .start            (start),
      .abort            (abort),
      .half_period      (half_period),
      .blank_cycles     (blank_cycles),
      .num_cycles       (num_cycles),
      .light_source_pin (light),
      .add_enable       (add_en),
      .subtract_enable  (sub_en),
      .counter_clear    (clr),
      .counter_latch    (latch),
      .busy             (busy),
      .done             (done),
      .config_error     (cerr),
      .cycles_completed (cycles_completed)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // o = {light, add, sub, clear, latch, busy, done, config_error}
   typedef struct {
      int          cyc;
      logic [7:0]  o;
      logic [15:0] c;
      bit          keep;   // cycles_completed expected to hold previous value
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 1'b0;
   logic [15:0] held = '0;

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         logic [7:0]  eo;
         logic [15:0] ec;
         logic [7:0]  got;
         eo = '0;
         ec = held;
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            failures++;
            checks++;
            $display("FAIL missed_entry cyc=%0d entry_cyc=%0d", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t e;
            e  = exp_q.pop_front();
            eo = e.o;
            if (!e.keep) held = e.c;
            ec = held;
         end
         got = {light, add_en, sub_en, clr, latch, busy, done, cerr};
         checks++;
         if (got !== eo || cycles_completed !== ec) begin
            failures++;
            $display("FAIL outputs cyc=%0d got o=%b cc=%0d expected o=%b cc=%0d",
                     cyc, got, cycles_completed, eo, ec);
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic bit cfg_valid(int h, int b, int n);
      return (h != 0) && (n != 0) && (!BLANK_EN || (b < h));
   endfunction

   // Expected waveform of an accepted run starting at absolute cycle c0,
   // cut short at relative cycle a (abort or reset), a<0 meaning none.
   task automatic push_run(int c0, int h, int b, int n, int a, bit is_rst);
      int beff, l, last, a_eff;
      beff  = BLANK_EN ? b : 0;
      l     = 2 + 2 * h * n;       // counter_latch
      last  = l + 1;               // done
      a_eff = (a < 0) ? last + 1 : a;
      for (int k = 0; k <= last && k < a_eff; k++) begin
         exp_t e;
         int   p, t, cc;
         e.cyc = c0 + k;
         e.o   = '0;
         e.keep = 1'b0;
         cc = 0;
         if (k >= 1) begin
            cc = (k - 1) / (2 * h);
            if (cc > n) cc = n;
            e.o[2] = 1'b1;                          // busy
         end
         if (k == 1) e.o[4] = 1'b1;                 // clear
         if (k >= 2 && k < l) begin
            p = (k - 2) / h;
            t = (k - 2) % h;
            e.o[7] = (p % 2 == 0);                  // light on in even phases
            e.o[6] = (p % 2 == 0) && (t >= beff);   // add window
            e.o[5] = (p % 2 == 1) && (t >= beff);   // subtract window
         end
         if (k == l)    e.o[3] = 1'b1;              // latch
         if (k == last) e.o[1] = 1'b1;              // done
         e.c = 16'(cc);
         exp_q.push_back(e);
      end
      if (a_eff <= last) begin
         exp_t z;
         z.cyc  = c0 + a_eff;
         z.o    = '0;
         z.c    = '0;
         z.keep = !is_rst;
         exp_q.push_back(z);
      end
   endtask

   // ---------------- stimulus ----------------
   // a: relative edge of abort/reset (-1 none); ign: relative edge of an
   // extra start with scrambled config while busy (-1 none).
   task automatic do_run(int h, int b, int n, int a, bit is_rst, int ign);
      int  c0, endk, l;
      bit  ok;
      @(negedge clk);
      reset        = 1'b0;
      start        = 1'b1;
      abort        = (a == 0);
      half_period  = 32'(h);
      blank_cycles = 16'(b);
      num_cycles   = 16'(n);
      c0 = cyc + 1;
      ok = cfg_valid(h, b, n);
      l  = 2 + 2 * h * n;
      if (a == 0) begin
         exp_t z;
         z.cyc = c0; z.o = '0; z.c = '0; z.keep = 1'b1;
         exp_q.push_back(z);
         endk = 0;
      end else if (ok) begin
         push_run(c0, h, b, n, a, is_rst);
         endk = (a > 0) ? a : l + 1;
      end else begin
         exp_t z;
         z.cyc = c0; z.o = 8'b0000_0001; z.c = '0; z.keep = 1'b1;
         exp_q.push_back(z);
         endk = 0;
      end
      for (int r = 1; r <= endk; r++) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         reset = 1'b0;
         if (r == a) begin
            if (is_rst) reset = 1'b1;
            else        abort = 1'b1;
         end
         if (r == ign) begin
            start        = 1'b1;
            half_period  = 32'($urandom_range(0, 7));
            blank_cycles = 16'($urandom_range(0, 7));
            num_cycles   = 16'($urandom_range(0, 4));
         end
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      mon_en = 1'b1;   // first check: reset state

      do_run(5, 2, 3, -1, 1'b0, -1);   // nominal run
      do_run(0, 2, 3, -1, 1'b0, -1);   // half_period = 0
      do_run(5, 5, 3, -1, 1'b0, -1);   // blank == half_period
      do_run(5, 2, 0, -1, 1'b0, -1);   // num_cycles = 0
      do_run(5, 2, 3,  9, 1'b0, -1);   // abort in first cycle
      do_run(5, 2, 3,  9, 1'b1, -1);   // reset mid off-phase
      do_run(5, 2, 3, -1, 1'b0, -1);   // normal run after reset
      do_run(5, 2, 3, -1, 1'b0,  6);   // ignored start while busy
      do_run(3, 1, 2, -1, 1'b0, 20);
      do_run(3, 1, 2,  0, 1'b0, -1);   // start with abort in idle
      do_run(2, 1, 1,  6, 1'b0, -1);   // abort in latch
      do_run(2, 1, 1,  7, 1'b0, -1);   // abort during done
      do_run(4, 3, 1, -1, 1'b0, -1);   // latch on cycle 10
      do_run(1, 0, 2, -1, 1'b0, -1);   // minimal phase length

      for (int i = 0; i < 30; i++) begin
         int h, b, n, mode, a, ign, l;
         bit rs;
         h    = $urandom_range(1, 6);
         n    = $urandom_range(1, 3);
         b    = BLANK_EN ? $urandom_range(0, h - 1) : $urandom_range(0, 7);
         mode = $urandom_range(0, 5);
         l    = 2 + 2 * h * n;
         a    = -1;
         rs   = 1'b0;
         ign  = -1;
         if (mode == 0) h = 0;
         if (mode == 1) n = 0;
         if (mode == 2) a = $urandom_range(0, l + 1);
         if (mode == 3) begin a = $urandom_range(1, l + 1); rs = 1'b1; end
         if (mode == 4) ign = $urandom_range(1, l);
         do_run(h, b, n, a, rs, ign);
      end

      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      reset = 1'b0;
      for (int w = 0; w < 200 && exp_q.size() > 0; w++) @(negedge clk);
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog timeout at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lockin_sequencer.md
# lockin_sequencer

Sequences one gated lock-in photon-counting acquisition. Drives the excitation light source and the add/subtract count-enable gates of the photon counter datapath, with an optional blanking window after each light transition. It clears the counters before a run and latches them after a programmed number of modulation cycles. It sits between the host/config registers and the counter datapath, replacing free-running modulation and integration timers with a start/abort-controlled run.

## Interface
Parameters:
- TIMER_WIDTH, 32: width of `half_period` and the phase timer.
- CYCLE_WIDTH, 16: width of `num_cycles`, `blank_cycles` and the cycle counter.

Ports:
- clock_50_mhz  in  1  system clock, 50 MHz; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request; honoured only in IDLE.
- abort  in  1  terminates a run; no latch is issued.
- half_period  in  TIMER_WIDTH  clocks per light-on phase and per light-off phase.
- blank_cycles  in  CYCLE_WIDTH  clocks at the start of each phase with both gates off.
- num_cycles  in  CYCLE_WIDTH  number of full on+off modulation cycles per run.
- light_source_pin  out  1  excitation drive.
- add_enable  out  1  counter gate for the light-on window.
- subtract_enable  out  1  counter gate for the light-off window.
- counter_clear  out  1  one-cycle clear strobe to the counters.
- counter_latch  out  1  one-cycle strobe to capture the add−subtract result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle strobe when a run completes normally.
- config_error  out  1  one-cycle strobe when `start` is rejected.
- cycles_completed  out  CYCLE_WIDTH  full modulation cycles finished in the current or last run.

## Operation
- States: IDLE, CLEAR, ON_PHASE, OFF_PHASE, LATCH, DONE.
- **IDLE:**
  - On `start`, validate the config: `half_period`≠0, `num_cycles`≠0, `blank_cycles`<`half_period`.
  - Invalid config: pulse `config_error`, stay in IDLE.
  - Valid config: copy all three config inputs into internal registers, zero `cycles_completed`, go to CLEAR.
  - Config inputs are ignored while busy.
- **CLEAR:** `counter_clear`=1 for one cycle, then go to ON_PHASE with phase timer=0.
- **ON_PHASE:**
  - `light_source_pin`=1.
  - `add_enable`=1 when timer ≥ `blank_cycles`.
  - When timer = `half_period`−1, go to OFF_PHASE and reset the timer.
- **OFF_PHASE:**
  - `light_source_pin`=0.
  - `subtract_enable`=1 when timer ≥ `blank_cycles`.
  - At timer = `half_period`−1, increment `cycles_completed`.
  - If the new count equals `num_cycles`, go to LATCH; otherwise go to ON_PHASE.
- **LATCH:** `counter_latch`=1 for one cycle, then go to DONE.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- **Gates:**
  - `add_enable` and `subtract_enable` are never high together.
  - Neither gate is high outside ON_PHASE/OFF_PHASE.
- **abort:**
  - In any non-IDLE state, the next state is IDLE, all outputs drop to 0 on that edge, and `cycles_completed` holds its value.
  - `abort` has priority over `start`, phase transitions, LATCH and DONE. An abort in LATCH suppresses `done`.
- `start` and `abort` in the same IDLE cycle: the run is not started and `config_error` is not pulsed.
- Width rules:
  - Timers compare at full width with no wrap inside a run.
  - `cycles_completed` cannot overflow, because `num_cycles` bounds it.

## Timing
- Reset values:
  - All outputs are 0 and `cycles_completed`=0.
  - State is IDLE.
- Reset mid-run behaves like abort, and it additionally zeroes `cycles_completed`.
- All outputs are registered.
- Cycle numbering from the `start` edge:
  - Cycle 0 is the clock edge where `start` is sampled. Cycle 1 is the next edge, and so on.
  - `busy` and `counter_clear` rise on cycle 1. `light_source_pin` rises on cycle 2.
  - Each phase lasts exactly `half_period` clocks. The light therefore has a period of 2·`half_period`.
  - `counter_latch` comes 2+2·`half_period`·`num_cycles` clocks after cycle 0.
  - `done` follows `counter_latch` by 1 clock. `busy` falls together with `done`.
- Gate windows:
  - Each gate is high for `half_period`−`blank_cycles` clocks per phase.
  - Each gate starts `blank_cycles` clocks after its phase edge.
- Back-to-back runs: a `start` sampled in the cycle after `done` is accepted.

## Configuration
- Macro: `LOCKIN_BLANKING_EN`.
- Defined:
  - Blanking works as described above.
  - The `blank_cycles`<`half_period` check applies.
- Undefined:
  - `blank_cycles` is ignored and treated as 0, so each gate equals its phase (`add_enable`=`light_source_pin` while busy).
  - The `blank_cycles` check is removed.
  - The port stays present but unused.

## Test plan
- Run with `half_period`=5, `blank_cycles`=2, `num_cycles`=3 → `counter_clear` pulses on cycle 1 and the light toggles every 5 clocks, 6 phases in total. Each gate is high 3 clocks per phase. `counter_latch` pulses on cycle 32 and `done` on cycle 33. `cycles_completed`=3.
- `half_period`=0, or `blank_cycles`=5 with `half_period`=5, or `num_cycles`=0 → `config_error` pulses one cycle and `busy` stays 0.
- `abort` at cycle 9 of the first scenario → all outputs 0 on the next edge. No `counter_latch` and no `done`. `cycles_completed`=0 (abort lands in the first cycle, before the first cycle completes); the value is retained.
- `reset` asserted mid-OFF_PHASE → all outputs 0 and `cycles_completed`=0. A subsequent `start` runs normally.
- `start` pulsed while busy, with changed config inputs → it is ignored, and the timing matches the original config exactly.
- Build without `LOCKIN_BLANKING_EN`, with `half_period`=4, `blank_cycles`=3, `num_cycles`=1 → start is accepted. `add_enable` is high for 4 clocks, then `subtract_enable` for 4 clocks. Latch lands on cycle 10.
